da_ctrl: RTL and testbench
==========================

DA_CTRL -- requirements
Module: da_ctrl

Interface
REQ-001 Parameter: NBITS, default 16, bit-serial cycles per sample in the da datapath.
REQ-002 Parameter: ROM_WORDS, default 2048, coefficient words per full load (8 ROMs x 256).
REQ-003 Parameter: TIMEOUT, default 24, max cycles from da_start to da_valid_out.
REQ-004 Port: clk  in  1  single clock; all state changes on posedge.
REQ-005 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-006 Port: load_req  in  1  pulse requesting full ROM (re)load.
REQ-007 Port: cfg_valid / cfg_ready  in / out  1 / 1  coefficient stream handshake.
REQ-008 Port: cfg_data  in  20  signed coefficient word.
REQ-009 Port: smp_valid / smp_ready  in / out  1 / 1  sample-set handshake.
REQ-010 Port: smp_data  in  64  eight unsigned 8-bit taps; [7:0]=A0 ... [63:56]=A7.
REQ-011 Port: res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-012 Port: res_data  out  38  signed accumulator result.
REQ-013 Port: rom_loaded, err  out  1 / 1  status flags.
REQ-014 Port: da_a  out  64  taps to datapath; da_cin  out  20; da_caddr  out  11; da_cload, da_valid_in, da_start  out  1 each.
REQ-015 Port: da_acc_out  in  38; da_valid_out  in  1  datapath result.

Function
REQ-016 States: IDLE, LOAD, READY, RUN, OUT; one-hot or binary, designer's choice.
REQ-017 IDLE: load_req -> LOAD; smp_ready=0; cfg_ready=0.
REQ-018 LOAD: cfg_ready=1; each cfg_valid&cfg_ready cycle drives, registered, da_cload=1, da_valid_in=1, da_caddr=addr, da_cin=cfg_data the next cycle; addr increments by 1.
REQ-019 LOAD ends on write number ROM_WORDS (addr ROM_WORDS-1): -> READY, rom_loaded=1, addr wraps to 0; cfg_valid low stalls without side effects.
REQ-020 READY: smp_ready=1 unless load_req high; smp_valid&smp_ready latches smp_data into da_a, -> RUN.
REQ-021 READY: load_req -> LOAD, rom_loaded cleared same edge; load_req wins over simultaneous smp_valid.
REQ-022 RUN: da_start=1 for exactly first RUN cycle; da_a held constant throughout RUN; cycle counter starts at 0.
REQ-023 RUN: da_valid_out=1 -> capture da_acc_out into res_data, -> OUT; earliest acceptance at counter >= NBITS-1, earlier da_valid_out ignored.
REQ-024 RUN: counter reaches TIMEOUT without accepted da_valid_out -> err=1 (sticky), -> READY, no result emitted.
REQ-025 OUT: res_valid=1, res_data stable until res_ready; res_valid&res_ready -> READY same edge.
REQ-026 load_req in LOAD, RUN, OUT ignored (not queued).
REQ-027 da_cload, da_valid_in zero outside LOAD write cycles; da_cin, da_caddr zero when da_cload=0.
REQ-028 Latency: smp handshake to res_valid = accepted da_valid_out cycle + 1.

Reset
REQ-029 resetn low, any state incl. mid-LOAD/RUN: state=IDLE, addr=0, counter=0, all outputs 0 (rom_loaded=0, err=0, res_valid=0, res_data=0, da_* = 0) asynchronously.
REQ-030 After resetn rises, first posedge evaluates from IDLE; err cleared only by reset.

Verification
REQ-031 Reset, load_req, stream 2048 words cfg_data=i%256 back-to-back -> da_caddr 0..2047 in order, da_cin=i%256, rom_loaded=1 after last, state READY.
REQ-032 Load with cfg_valid toggling 1/0 -> same 2048 writes, no duplicate or skipped address.
REQ-033 smp_data all taps=0x05, model da_valid_out at cycle 15 with acc=0x12345 -> da_start one cycle, res_data=0x12345, res_valid held while res_ready=0 for 3 cycles.
REQ-034 No da_valid_out after start -> err=1 at cycle TIMEOUT, back in READY, res_valid never 1.
REQ-035 load_req and smp_valid same cycle in READY -> LOAD entered, sample not accepted, rom_loaded=0.
REQ-036 resetn low mid-RUN (cycle 7) -> all outputs 0 immediately, IDLE; subsequent smp_valid not accepted until reload.

Source files
------------

// File: rtl/da_ctrl.sv
// Control FSM for a bit-serial distributed-arithmetic datapath: loads the
// coefficient ROMs, issues sample sets, collects results and flags timeouts.
module da_ctrl #(
    parameter int unsigned NBITS     = 16,
    parameter int unsigned ROM_WORDS = 2048,
    parameter int unsigned TIMEOUT   = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_req,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [19:0] cfg_data,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [63:0] smp_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [37:0] res_data,
    output logic        rom_loaded,
    output logic        err,
    output logic [63:0] da_a,
    output logic [19:0] da_cin,
    output logic [10:0] da_caddr,
    output logic        da_cload,
    output logic        da_valid_in,
    output logic        da_start,
    input  logic [37:0] da_acc_out,
    input  logic        da_valid_out
);

    localparam int unsigned AW    = 11;
    localparam int unsigned CIN_W = 20;
    localparam int unsigned ACC_W = 38;
    localparam int unsigned TAP_W = 64;
    localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_addr;
    logic [CW-1:0]      r_cnt;
    logic               r_cfg_ready;
    logic               r_res_valid;
    logic [ACC_W-1:0]   r_res_data;
    logic               r_rom_loaded;
    logic               r_err;
    logic [TAP_W-1:0]   r_da_a;
    logic [CIN_W-1:0]   r_da_cin;
    logic [AW-1:0]      r_da_caddr;
    logic               r_da_cload;
    logic               r_da_start;

    logic w_cfg_fire;
    logic w_last_word;
    logic w_smp_fire;
    logic w_res_accept;
    logic w_timeout;

    assign w_cfg_fire   = (r_state == S_LOAD) && cfg_valid;
    assign w_last_word  = (r_addr == AW'(ROM_WORDS - 1));
    assign w_smp_fire   = (r_state == S_READY) && smp_valid && !load_req;
    // Results arriving before the serial pass can have finished are spurious
    assign w_res_accept = (r_state == S_RUN) && da_valid_out && (r_cnt >= CW'(NBITS - 1));
    assign w_timeout    = (r_state == S_RUN) && !w_res_accept && (r_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (load_req) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_cfg_fire && w_last_word) w_state_nxt = S_READY;
            S_READY: begin
                if (load_req)       w_state_nxt = S_LOAD;
                else if (smp_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_res_accept)   w_state_nxt = S_OUT;
                else if (w_timeout) w_state_nxt = S_READY;
            end
            S_OUT:   if (res_ready) w_state_nxt = S_READY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, ROM address and RUN cycle counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_cfg_ready  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_rom_loaded <= 1'b0;
            r_err        <= 1'b0;
            r_da_a       <= '0;
            r_da_cin     <= '0;
            r_da_caddr   <= '0;
            r_da_cload   <= 1'b0;
            r_da_start   <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == S_LOAD);
            r_res_valid <= (w_state_nxt == S_OUT);
            r_da_cload  <= w_cfg_fire;
            r_da_cin    <= w_cfg_fire ? cfg_data : '0;
            r_da_caddr  <= w_cfg_fire ? r_addr : '0;
            r_da_start  <= w_smp_fire;

            if (w_cfg_fire) r_addr <= w_last_word ? '0 : r_addr + AW'(1);

            if (w_cfg_fire && w_last_word)             r_rom_loaded <= 1'b1;
            else if ((r_state == S_READY) && load_req) r_rom_loaded <= 1'b0;

            if (w_smp_fire) begin
                r_da_a <= smp_data;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_res_accept) r_res_data <= da_acc_out;
            if (w_timeout)    r_err      <= 1'b1;
        end
    end

    assign cfg_ready   = r_cfg_ready;
    // Depends on load_req directly so a reload request always wins the same cycle
    assign smp_ready   = (r_state == S_READY) && !load_req;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign rom_loaded  = r_rom_loaded;
    assign err         = r_err;
    assign da_a        = r_da_a;
    assign da_cin      = r_da_cin;
    assign da_caddr    = r_da_caddr;
    assign da_cload    = r_da_cload;
    assign da_valid_in = r_da_cload;
    assign da_start    = r_da_start;

endmodule

// File: tb/tb_da_ctrl.sv
// Directed + randomized bench for da_ctrl; expected results come from a
// transaction-level model of ROM writes and sample/result timing.
module tb_da_ctrl;

    localparam int unsigned NBITS     = 16;
    localparam int unsigned ROM_WORDS = 2048;
    localparam int unsigned TIMEOUT   = 24;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load_req = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [19:0] cfg_data = '0;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [63:0] smp_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [37:0] res_data;
    logic        rom_loaded;
    logic        err;
    logic [63:0] da_a;
    logic [19:0] da_cin;
    logic [10:0] da_caddr;
    logic        da_cload;
    logic        da_valid_in;
    logic        da_start;
    logic [37:0] da_acc_out = '0;
    logic        da_valid_out = 1'b0;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    bit exp_err = 1'b0;

    logic [10:0] mon_addr[$];
    logic [19:0] mon_cin[$];

    always #5 clk = ~clk;

    da_ctrl #(.NBITS(NBITS), .ROM_WORDS(ROM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .load_req(load_req),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .rom_loaded(rom_loaded), .err(err),
        .da_a(da_a), .da_cin(da_cin), .da_caddr(da_caddr),
        .da_cload(da_cload), .da_valid_in(da_valid_in), .da_start(da_start),
        .da_acc_out(da_acc_out), .da_valid_out(da_valid_out)
    );

    // Record every ROM write seen on the datapath port; flag idle-cycle garbage
    always @(negedge clk) begin
        if (da_cload === 1'b1) begin
            mon_addr.push_back(da_caddr);
            mon_cin.push_back(da_cin);
            if (da_valid_in !== 1'b1) viol++;
        end else if (da_cload !== 1'b0 || da_valid_in !== 1'b0 ||
                     da_cin !== 20'd0 || da_caddr !== 11'd0) begin
            viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_valid"},  64'(res_valid),  64'd0);
        chk({tag, "_res_data"},   64'(res_data),   64'd0);
        chk({tag, "_rom_loaded"}, 64'(rom_loaded), 64'd0);
        chk({tag, "_err"},        64'(err),        64'd0);
        chk({tag, "_da_a"},       da_a,            64'd0);
        chk({tag, "_da_cin"},     64'(da_cin),     64'd0);
        chk({tag, "_da_caddr"},   64'(da_caddr),   64'd0);
        chk({tag, "_da_cload"},   64'(da_cload),   64'd0);
        chk({tag, "_da_vin"},     64'(da_valid_in), 64'd0);
        chk({tag, "_da_start"},   64'(da_start),   64'd0);
        chk({tag, "_cfg_ready"},  64'(cfg_ready),  64'd0);
        chk({tag, "_smp_ready"},  64'(smp_ready),  64'd0);
    endtask

    // Caller is just past a posedge with the DUT in LOAD
    task automatic load_stream(input bit toggle, input bit rnd);
        logic [19:0] exp_w[$];
        logic [19:0] w;
        int errs;
        mon_addr.delete();
        mon_cin.delete();
        for (int i = 0; i < int'(ROM_WORDS); i++) begin
            if (toggle) begin
                cfg_valid = 1'b0;
                cfg_data  = 20'($urandom);
                @(posedge clk); #1;
            end
            w = rnd ? 20'($urandom) : 20'(i % 256);
            exp_w.push_back(w);
            cfg_valid = 1'b1;
            cfg_data  = w;
            @(negedge clk);
            if (i == 0 || i == int'(ROM_WORDS) - 1) begin
                chk("load_cfg_ready", 64'(cfg_ready), 64'd1);
                chk("load_rom_loaded_mid", 64'(rom_loaded), 64'd0);
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("load_done_rom_loaded", 64'(rom_loaded), 64'd1);
        chk("load_done_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("load_done_smp_ready", 64'(smp_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("load_write_count", 64'(mon_addr.size()), 64'(ROM_WORDS));
        errs = 0;
        for (int i = 0; i < int'(ROM_WORDS); i++) begin
            if (i >= mon_addr.size()) errs++;
            else if (mon_addr[i] !== 11'(i) || mon_cin[i] !== exp_w[i]) errs++;
        end
        chk("load_write_seq_errs", 64'(errs), 64'd0);
        chk("load_idle_viol", 64'(viol), 64'd0);
    endtask

    // Issue one sample set from READY; vmask[k] drives da_valid_out in RUN cycle k
    task automatic run_sample(input logic [63:0] data, input logic [TIMEOUT-1:0] vmask,
                              input int hold, input bit fix, input logic [37:0] acc_fix);
        logic [37:0] acc[TIMEOUT];
        int fire;
        int last;
        fire = -1;
        for (int k = 0; k < int'(TIMEOUT); k++)
            acc[k] = fix ? acc_fix : 38'({$urandom, $urandom});
        for (int k = int'(NBITS) - 1; k < int'(TIMEOUT); k++)
            if (vmask[k] && fire < 0) fire = k;
        last = (fire >= 0) ? fire : int'(TIMEOUT) - 1;

        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_data  = data;
        @(negedge clk);
        chk("smp_ready", 64'(smp_ready), 64'd1);
        @(posedge clk); #1;
        smp_valid = 1'b0;
        smp_data  = {$urandom, $urandom};
        for (int k = 0; k <= last; k++) begin
            da_valid_out = vmask[k];
            da_acc_out   = acc[k];
            @(negedge clk);
            chk("run_da_a", da_a, data);
            if (k < 2) chk("run_da_start", 64'(da_start), 64'(k == 0));
            chk("run_res_valid", 64'(res_valid), 64'd0);
            @(posedge clk); #1;
        end
        da_valid_out = 1'b0;
        da_acc_out   = '0;
        @(negedge clk);
        if (fire >= 0) begin
            chk("out_res_valid", 64'(res_valid), 64'd1);
            chk("out_res_data", 64'(res_data), 64'(acc[fire]));
            chk("out_err", 64'(err), 64'(exp_err));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_res_valid", 64'(res_valid), 64'd1);
                chk("hold_res_data", 64'(res_data), 64'(acc[fire]));
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(negedge clk);
            chk("hs_res_valid", 64'(res_valid), 64'd1);
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            chk("post_res_valid", 64'(res_valid), 64'd0);
            chk("post_smp_ready", 64'(smp_ready), 64'd1);
        end else begin
            exp_err = 1'b1;
            chk("tmo_err", 64'(err), 64'd1);
            chk("tmo_res_valid", 64'(res_valid), 64'd0);
            chk("tmo_smp_ready", 64'(smp_ready), 64'd1);
        end
    endtask

    initial begin
        logic [TIMEOUT-1:0] vm;

        // Reset state
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        smp_valid = 1'b1;
        @(negedge clk);
        chk("idle_smp_ready", 64'(smp_ready), 64'd0);
        chk("idle_cfg_ready", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1;
        smp_valid = 1'b0;

        // Full back-to-back load with cfg_data = i % 256
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        load_stream(1'b0, 1'b0);

        // Directed sample: taps 0x05, valid at cycle NBITS-1, result held 3 cycles
        vm = '0;
        vm[NBITS-1] = 1'b1;
        run_sample(64'h0505_0505_0505_0505, vm, 3, 1'b1, 38'h12345);

        // Early-only pulse followed by a late accepted one
        vm = '0;
        vm[3] = 1'b1;
        vm[20] = 1'b1;
        run_sample({$urandom, $urandom}, vm, 0, 1'b0, '0);

        // Randomized sample sets; some time out, err stays sticky afterwards
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < int'(TIMEOUT); k++) vm[k] = ($urandom_range(0, 99) < 12);
            run_sample({$urandom, $urandom}, vm, int'($urandom_range(0, 3)), 1'b0, '0);
        end

        // Directed timeout: no da_valid_out at all
        run_sample({$urandom, $urandom}, '0, 0, 1'b0, '0);

        // load_req and smp_valid together in READY: reload wins
        @(posedge clk); #1;
        load_req  = 1'b1;
        smp_valid = 1'b1;
        smp_data  = {$urandom, $urandom};
        @(negedge clk);
        chk("collide_smp_ready", 64'(smp_ready), 64'd0);
        @(posedge clk); #1;
        load_req  = 1'b0;
        smp_valid = 1'b0;
        @(negedge clk);
        chk("collide_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("collide_rom_loaded", 64'(rom_loaded), 64'd0);
        chk("collide_da_start", 64'(da_start), 64'd0);
        chk("collide_err_sticky", 64'(err), 64'(exp_err));
        @(posedge clk); #1;

        // Reload with a stalling stream and random coefficients
        load_stream(1'b1, 1'b1);

        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < int'(TIMEOUT); k++) vm[k] = ($urandom_range(0, 99) < 25);
            run_sample({$urandom, $urandom}, vm, int'($urandom_range(0, 2)), 1'b0, '0);
        end

        // Reset in RUN cycle 7
        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_data  = {$urandom, $urandom};
        @(posedge clk); #1;
        smp_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        exp_err = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        smp_valid = 1'b1;
        smp_data  = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            chk("after_reset_smp_ready", 64'(smp_ready), 64'd0);
            chk("after_reset_da_start", 64'(da_start), 64'd0);
            chk("after_reset_rom_loaded", 64'(rom_loaded), 64'd0);
            @(posedge clk); #1;
        end
        smp_valid = 1'b0;
        @(negedge clk);
        chk("final_da_a", da_a, 64'd0);
        chk("final_viol", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
